// File: rtl/spi_memory_pkg.sv
// Shared constants for the spi_memory SPI-slave register file.
package spi_memory_pkg;

    localparam int ADDR_W    = 7;
    localparam int DATA_W    = 8;
    localparam int MEM_DEPTH = 128;
    localparam int BIT_CNT_W = 3;

    localparam logic RW_READ = 1'b1;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE       = 3'd0;
    localparam state_t ST_ADDR       = 3'd1;
    localparam state_t ST_WRITE_DATA = 3'd2;
    localparam state_t ST_READ_DATA  = 3'd3;
    localparam state_t ST_DONE       = 3'd4;

endpackage

// File: rtl/spi_input_conditioner.sv
// Pin synchronizer with one-clk rise/fall pulses; reset loads the pin's idle level.
module spi_input_conditioner #(
    parameter int   SYNC_STAGES = 2,
    parameter logic IDLE_LEVEL  = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic pin,
    output logic sync,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] stages;
    logic                   prev;

    // prev holds the previous synchronized level so the pulses are registered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stages <= {SYNC_STAGES{IDLE_LEVEL}};
            prev   <= IDLE_LEVEL;
            rise   <= 1'b0;
            fall   <= 1'b0;
        end else begin
            stages <= {stages[SYNC_STAGES-2:0], pin};
            prev   <= stages[SYNC_STAGES-1];
            rise   <= stages[SYNC_STAGES-1] & ~prev;
            fall   <= ~stages[SYNC_STAGES-1] & prev;
        end
    end

    assign sync = stages[SYNC_STAGES-1];

endmodule

// File: rtl/spi_memory.sv
// SPI mode-0 slave in front of a 128 x 8 register memory.
// Define MISO_TRISTATE_EN to release miso_pin outside the read phase.
module spi_memory
    import spi_memory_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       sclk_pin,
    input  logic       cs_pin,
    output logic       miso_pin,
    input  logic       mosi_pin,
    output logic [3:0] leds
);

    logic sclk_sync, sclk_rise, sclk_fall;
    logic cs_sync, cs_rise, cs_fall;
    logic mosi_sync, mosi_rise, mosi_fall;
    logic unused_pulses;

    spi_input_conditioner #(.SYNC_STAGES(SYNC_STAGES), .IDLE_LEVEL(1'b0)) u_sclk (
        .clk(clk), .rst(reset), .pin(sclk_pin),
        .sync(sclk_sync), .rise(sclk_rise), .fall(sclk_fall)
    );

    spi_input_conditioner #(.SYNC_STAGES(SYNC_STAGES), .IDLE_LEVEL(1'b1)) u_cs (
        .clk(clk), .rst(reset), .pin(cs_pin),
        .sync(cs_sync), .rise(cs_rise), .fall(cs_fall)
    );

    spi_input_conditioner #(.SYNC_STAGES(SYNC_STAGES), .IDLE_LEVEL(1'b0)) u_mosi (
        .clk(clk), .rst(reset), .pin(mosi_pin),
        .sync(mosi_sync), .rise(mosi_rise), .fall(mosi_fall)
    );

    assign unused_pulses = ^{sclk_sync, cs_rise, cs_fall, mosi_rise, mosi_fall};

    state_t               state;
    logic [BIT_CNT_W-1:0] bit_cnt;
    logic [DATA_W-1:0]    shift_in;
    logic [DATA_W-1:0]    shift_out;
    logic [ADDR_W-1:0]    addr;
    logic                 miso_q;
    logic                 read_done;

    logic [DATA_W-1:0]    mem [MEM_DEPTH];
    logic                 last_bit;
    logic                 mem_we;
    logic [DATA_W-1:0]    write_data;
    logic [ADDR_W-1:0]    cmd_addr;

    assign last_bit   = (bit_cnt == '1);
    assign write_data = {shift_in[DATA_W-2:0], mosi_sync};
    assign cmd_addr   = shift_in[ADDR_W-1:0];
    // cs high overrides any sclk edge in the same clk, so aborts never write.
    assign mem_we     = (state == ST_WRITE_DATA) && sclk_rise && last_bit && !cs_sync;

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[addr] <= write_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ST_IDLE;
            bit_cnt   <= '0;
            shift_in  <= '0;
            shift_out <= '0;
            addr      <= '0;
            miso_q    <= 1'b0;
            read_done <= 1'b0;
        end else if (cs_sync) begin
            state     <= ST_IDLE;
            bit_cnt   <= '0;
            shift_in  <= '0;
            shift_out <= '0;
            miso_q    <= 1'b0;
            read_done <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: state <= ST_ADDR;
                ST_ADDR: begin
                    if (sclk_rise) begin
                        shift_in <= write_data;
                        bit_cnt  <= bit_cnt + 1'b1;
                        if (last_bit) begin
                            addr <= cmd_addr;
                            if (mosi_sync == RW_READ) begin
                                shift_out <= mem[cmd_addr];
                                state     <= ST_READ_DATA;
                            end else begin
                                state     <= ST_WRITE_DATA;
                            end
                        end
                    end
                end
                ST_WRITE_DATA: begin
                    if (sclk_rise) begin
                        shift_in <= write_data;
                        bit_cnt  <= bit_cnt + 1'b1;
                        if (last_bit) begin
                            state <= ST_DONE;
                        end
                    end
                end
                ST_READ_DATA: begin
                    if (sclk_fall) begin
                        miso_q    <= shift_out[DATA_W-1];
                        shift_out <= {shift_out[DATA_W-2:0], 1'b0};
                        bit_cnt   <= bit_cnt + 1'b1;
                        if (last_bit) begin
                            state     <= ST_DONE;
                            read_done <= 1'b1;
                        end
                    end
                end
                ST_DONE: state <= ST_DONE;
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifdef MISO_TRISTATE_EN
    assign miso_pin = ((state == ST_READ_DATA) || ((state == ST_DONE) && read_done)) ? miso_q : 1'bz;
`else
    assign miso_pin = miso_q;
`endif

    assign leds = {~cs_sync, state};

endmodule

// File: tb/tb_spi_memory.sv
// Scoreboard bench for spi_memory: read bits are queued from a memory model and popped per MISO sample.
module tb_spi_memory;

    localparam int HALF = 8;

`ifdef MISO_TRISTATE_EN
    localparam logic IDLE_MISO = 1'bz;
`else
    localparam logic IDLE_MISO = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic       sclk_pin;
    logic       cs_pin;
    logic       mosi_pin;
    logic       miso_pin;
    logic [3:0] leds;

    int checks = 0;
    int errors = 0;

    logic [7:0] model_mem [128];
    logic       sb [$];

    always #5 clk = ~clk;

    spi_memory #(.SYNC_STAGES(2)) dut (
        .clk(clk),
        .reset(reset),
        .sclk_pin(sclk_pin),
        .cs_pin(cs_pin),
        .miso_pin(miso_pin),
        .mosi_pin(mosi_pin),
        .leds(leds)
    );

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
    endtask

    // Mode-0 transfer of nbits; bits past 16 are extra clocks with MOSI high.
    task automatic spi_xfer(input logic [7:0] cmd, input logic [7:0] wdata, input int nbits);
        logic [31:0] word;
        logic [6:0]  a;
        word = {cmd, wdata, 16'hFFFF};
        a    = cmd[7:1];
        if (nbits >= 16) begin
            if (cmd[0]) begin
                for (int b = 7; b >= 0; b--) sb.push_back(model_mem[a][b]);
            end else begin
                model_mem[a] = wdata;
            end
        end
        cs_pin = 1'b0;
        wait_clk(HALF);
        @(negedge clk);
        check("leds_addr", 8'(leds), 8'h09);
        check("miso_cmd", 8'(miso_pin), 8'(IDLE_MISO));
        for (int i = 0; i < nbits; i++) begin
            mosi_pin = word[31-i];
            wait_clk(HALF);
            sclk_pin = 1'b1;
            wait_clk(HALF);
            sclk_pin = 1'b0;
            wait_clk(HALF);
            @(negedge clk);
            if (cmd[0] && i >= 7 && i <= 14) begin
                if (sb.size() == 0) check("sb_underflow", 8'd1, 8'd0);
                else check("miso_bit", 8'(miso_pin), 8'(sb.pop_front()));
            end
        end
        mosi_pin = 1'b0;
        if (nbits >= 16) begin
            check("leds_done", 8'(leds), 8'h0C);
            if (cmd[0]) check("miso_hold", 8'(miso_pin), 8'(model_mem[a][0]));
        end
    endtask

    task automatic end_xfer();
        cs_pin = 1'b1;
        wait_clk(HALF);
        @(negedge clk);
        check("miso_idle", 8'(miso_pin), 8'(IDLE_MISO));
        check("leds_idle", 8'(leds), 8'h00);
    endtask

    initial begin
        logic [6:0] ra;
        logic [7:0] rd;
        reset    = 1'b1;
        cs_pin   = 1'b1;
        sclk_pin = 1'b0;
        mosi_pin = 1'b0;
        wait_clk(4);
        @(negedge clk);
        check("reset_leds", 8'(leds), 8'h00);
        check("reset_miso", 8'(miso_pin), 8'(IDLE_MISO));
        reset = 1'b0;
        wait_clk(HALF);

        // Reset in the middle of a command byte.
        spi_xfer(8'h03, 8'h00, 5);
        reset = 1'b1;
        wait_clk(2);
        @(negedge clk);
        check("midreset_leds", 8'(leds), 8'h00);
        check("midreset_miso", 8'(miso_pin), 8'(IDLE_MISO));
        cs_pin = 1'b1;
        wait_clk(2);
        reset = 1'b0;
        end_xfer();

        spi_xfer(8'h00, 8'hFF, 16);
        end_xfer();
        spi_xfer(8'h01, 8'h00, 16);
        end_xfer();

        spi_xfer(8'hFE, 8'hA5, 16);
        end_xfer();
        spi_xfer(8'hFF, 8'h00, 16);
        end_xfer();

        // Abort after 4 data bits must leave the old value.
        spi_xfer(8'h20, 8'h3C, 16);
        end_xfer();
        spi_xfer(8'h20, 8'hC3, 12);
        end_xfer();
        spi_xfer(8'h21, 8'h00, 16);
        end_xfer();

        // Extra sclk edges after DONE must not write again.
        spi_xfer(8'h40, 8'h5A, 24);
        end_xfer();
        spi_xfer(8'h41, 8'h00, 16);
        end_xfer();

        for (int k = 0; k < 3; k++) begin
            ra = 7'($urandom_range(1, 126));
            rd = 8'($urandom_range(0, 255));
            spi_xfer({ra, 1'b0}, rd, 16);
            end_xfer();
            spi_xfer({ra, 1'b1}, 8'h00, 16);
            end_xfer();
        end

        check("sb_empty", 8'(sb.size()), 8'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/spi_memory.md
Name: spi_memory

Overview:
- SPI mode-0 slave fronting a 128 x 8-bit register memory; intended as an FPGA top-level peripheral driven by an external SPI master.
- All SPI pins are asynchronous to clk. They are synchronized and edge-detected inside the block.
- Each transaction carries one command byte (7-bit address + R/W bit), then one data byte written on MOSI or read on MISO.
- leds expose FSM state for board debug.

Parameters:
- SYNC_STAGES, 2, number of flip-flop stages in each pin synchronizer (minimum 2).

Ports:
- clk  input  1  system clock; all logic is in this domain.
- reset  input  1  asynchronous, active-high reset.
- sclk_pin  input  1  SPI serial clock from the master; asynchronous.
- cs_pin  input  1  chip select, active-low; asynchronous.
- miso_pin  output  1  serial data to the master.
- mosi_pin  input  1  serial data from the master; asynchronous.
- leds  output  4  debug: leds[2:0] = FSM state code, leds[3] = synchronized cs active (cs low).

Behaviour:
- Input conditioning:
  - Each pin passes through a SYNC_STAGES flop synchronizer.
  - sclk additionally produces one-clk rise and fall pulses from the last two sync stages.
  - All FSM decisions use synchronized values.
  - Latency from pin edge to pulse is SYNC_STAGES+1 clk.
- Bit order and timing:
  - Bits are MSB first.
  - MOSI is sampled on sclk rise pulses.
  - MISO changes on sclk fall pulses.
- Command byte: bits[7:1] = address, bit[0] = R/W (1 = read, 0 = write).
- FSM states and codes: IDLE=0, ADDR=1, WRITE_DATA=2, READ_DATA=3, DONE=4.
- IDLE (cs high):
  - Bit counter cleared, shift registers cleared.
  - Sync cs goes low -> ADDR.
- ADDR:
  - Shift in MOSI on each rise.
  - On the 8th rise, latch address.
  - R/W=0 -> WRITE_DATA.
  - R/W=1 -> load read shift register with mem[address] in that same clk -> READ_DATA.
- WRITE_DATA:
  - Shift in 8 bits on rises.
  - On the 8th rise, mem[address] <= data byte -> DONE.
  - A write takes effect exactly once per transaction.
- READ_DATA:
  - On each fall, miso register <= shift[7] and shift left.
  - The first fall after the command byte presents data bit 7.
  - After 8 falls -> DONE; the miso register holds bit 0 until the next fall or cs high.
  - MOSI is ignored.
- DONE: ignore all sclk activity until cs high.
- cs high (synchronized) in any state:
  - -> IDLE next clk; a partial transaction is aborted with no memory write.
  - miso register cleared to 0.
- Memory: 128 x 8, synchronous write, combinational or registered read acceptable; the read value must be available before the first fall pulse. Contents are not reset.
- Reset: FSM=IDLE, counters=0, shift registers=0, miso_pin=0, leds=4'b0000, synchronizer flops = idle levels (cs=1, sclk=0, mosi=0).
- Simultaneous cs rise and sclk edge: cs wins, and the edge is ignored.
- Rise and fall pulses are never simultaneous by construction.
- Address wrap is not applicable: one byte per transaction; a multi-byte burst is not supported.

Optional Feature:
- MISO_TRISTATE_EN defined: miso_pin is high-Z whenever the state is not READ_DATA or DONE-after-read, allowing multi-slave bus sharing.
- MISO_TRISTATE_EN undefined: miso_pin is always driven; it is 0 outside the read phase.

Decomposition:
- Package spi_memory_pkg holds:
  - state enum and codes;
  - ADDR_W=7, DATA_W=8, MEM_DEPTH=128;
  - RW_READ=1'b1 constant;
  - bit-count width.
- Sub-module spi_input_conditioner (SYNC_STAGES synchronizer plus rise/fall pulse outputs), instantiated once each for sclk_pin, cs_pin and mosi_pin.
- FSM, shift registers and memory stay in the top module.

Test Plan:
- Reset: assert reset mid-transaction -> miso_pin=0, leds=0, FSM IDLE; next transaction behaves normally.
- Write/read at address 0x00:
  - cs low, 16 rises with MOSI 0x00 then 0xFF -> mem[0]=0xFF.
  - New transaction with command 0x01 -> 8 falls sample MISO 1,1,1,1,1,1,1,1.
  - Raise cs -> miso_pin returns to 0.
- Pattern at max address: write 0xA5 to address 0x7F (command 0xFE) -> read with command 0xFF returns 1,0,1,0,0,1,0,1.
- Abort: write command to address 0x10, 4 data bits, cs high -> mem[0x10] unchanged on a subsequent read.
- Post-DONE: extra sclk edges after a completed write -> no second write; leds[2:0]=4 until cs high, then 0.
- MISO_TRISTATE_EN: with the macro defined, miso_pin = Z while idle and during the command byte; driven during the read data phase.
